// File: rtl/mux_arb_reg_if.sv
//------------------------------------------------------------------------------
// mux_arb_reg_if : producer/consumer bundle for the registered N:1 selector
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mux_arb_reg_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
);
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;
  logic               out_ready;

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );
endinterface

`default_nettype wire

// File: rtl/mux_arb_reg.sv
//------------------------------------------------------------------------------
// mux_arb_reg : registered N:1 selector, explicit select or round-robin grant
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux_arb_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mux_arb_reg_if.slave      bus
);

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SELW-1:0]     r_out_chan;
  logic [SELW-1:0]     r_ptr;

  logic                w_load_en;
  logic                w_grant;
  logic [SELW-1:0]     w_cand;
  logic [WIDTH-1:0]    w_cand_data;
  logic [N-1:0]        w_in_ready;
  logic [SELW-1:0]     w_ptr_next;

  assign w_load_en = !r_out_valid || bus.out_ready;

  always_comb begin
    int idx;
    w_grant = 1'b0;
    w_cand  = '0;
    idx     = 0;
    if (!bus.mode) begin
      w_cand = bus.sel;
      if (int'(bus.sel) < N) begin
        w_grant = bus.in_valid[bus.sel];
      end
    end else begin
      // Scan starting at the pointer, wrapping; first valid channel wins
      for (int k = 0; k < N; k++) begin
        idx = int'(r_ptr) + k;
        if (idx >= N) begin
          idx = idx - N;
        end
        if (!w_grant && bus.in_valid[idx]) begin
          w_grant = 1'b1;
          w_cand  = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    w_cand_data = '0;
    w_in_ready  = '0;
    for (int i = 0; i < N; i++) begin
      if (SELW'(i) == w_cand) begin
        w_cand_data = bus.in_data[i*WIDTH +: WIDTH];
        w_in_ready[i] = w_load_en && w_grant && !rst;
      end
    end
  end

  assign w_ptr_next = (int'(w_cand) == N - 1) ? '0 : w_cand + SELW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
    end else if (w_load_en) begin
      if (w_grant) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_cand_data;
        r_out_chan  <= w_cand;
        if (bus.mode) begin
          r_ptr <= w_ptr_next;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_chan  = r_out_chan;

endmodule

`default_nettype wire

// File: doc/mux_arb_reg.md
# mux_arb_reg

Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshake and two selection modes: explicit select or round-robin arbitration among valid channels. It sits in the datapath wherever several producers (ALU result, memory read data, immediate, PC+4, …) compete for one consumer, replacing fixed 2:1 combinational selectors with a single-stage registered, back-pressure-aware selector.

## Interface
- WIDTH, 32, data width per channel
- N, 4, number of input channels (N ≥ 2, power of two not required)
- SELW, $clog2(N), width of select and channel index fields
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = explicit select via sel; 1 = round-robin arbitration
- sel  input  SELW  channel index used in mode 0
- in_valid  input  N  per-channel valid
- in_data  input  N*WIDTH  channel i data at [i*WIDTH +: WIDTH]
- in_ready  output  N  one-hot grant; channel i transfers when in_valid[i] & in_ready[i]
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered selected data
- out_chan  output  SELW  index of channel that produced out_data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Reset: out_valid=0, out_data=0, out_chan=0, internal round-robin pointer ptr=0; in_ready=0 while rst is high.
- load_en = !out_valid | out_ready (output register empty or draining this cycle).
- Candidate selection (combinational, evaluated every cycle):
  - mode 0: candidate = sel; granted iff sel < N and in_valid[sel]. sel ≥ N → no grant.
  - mode 1: scan channels ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap mod N); candidate = first with in_valid set; none valid → no grant.
- in_ready[c] = load_en & granted & (c == candidate); at most one bit set, never set for an invalid channel.
- On a transfer (any in_ready bit with matching in_valid): out_data ← in_data[candidate], out_chan ← candidate, out_valid ← 1.
- load_en with no grant: out_valid ← 0 (out_data/out_chan hold last values).
- !load_en (out_valid & !out_ready): out_valid, out_data, out_chan hold; in_ready = 0.
- ptr update: only on a mode-1 transfer, ptr ← (candidate+1) mod N (wrap N-1 → 0). Mode-0 transfers leave ptr unchanged.
- mode and sel changes take effect in the same cycle; no flush of the output register.
- rst asserted mid-operation: next edge forces reset values; word in output register is discarded.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 word/cycle while out_ready held high and a valid candidate exists.
- Simultaneous drain and fill: out_valid & out_ready & grant in the same cycle → new word loaded, out_valid stays 1, no bubble.
- Back-pressure: while out_valid & !out_ready, out_data and out_chan stable cycle to cycle.
- in_ready depends combinationally on in_valid, mode, sel, out_valid, out_ready; no combinational path from in_data to any output.
- Fairness (mode 1): with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,… one per cycle.

## Test plan
- Reset: hold rst 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_chan=0, in_ready=0000; first cycle after release in mode 1 grants channel 0.
- Mode 0 select: N=4, in_data = {0x44444444,0x33333333,0x22222222,0x11111111}, in_valid=1111, sel=2, out_ready=1 → in_ready=0100, next cycle out_data=0x33333333, out_chan=2; sel=5 (N=8 build, N-1=7 ok; N=4 build with SELW widened) or in_valid[sel]=0 → in_ready=0, out_valid drops next cycle.
- Round-robin wrap: mode 1, in_valid=1111, out_ready=1 for 6 cycles → out_chan sequence 0,1,2,3,0,1; then in_valid=1001 with ptr=2 → grant channel 3, then 0.
- Back-pressure: out_valid=1 with out_data=0xDEADBEEF, out_ready=0 for 3 cycles while inputs change → out_data=0xDEADBEEF held, in_ready=0000; out_ready=1 → new word loaded same cycle, no bubble.
- Mode switch: mode 1 with ptr=3, switch to mode 0 sel=1 for 2 transfers → ptr remains 3; return to mode 1 with in_valid=1111 → next grant channel 3.
- Reset mid-stream: rst pulsed while out_valid=1, out_ready=0 → next cycle out_valid=0, ptr=0, word lost.
